// File: rtl/usb_tx_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_arb_pkg                                                       |
// | Shared types and defaults for the USB serial to-host TX arbiter.     |
// | Contents: FSM state enum, default requester count, default maximum   |
// |           packet length, byte width.                                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package usb_tx_arb_pkg;

  localparam int BYTE_W      = 8;
  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_MAX_PKT = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/usb_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_rr_picker                                                        |
// | Combinational round-robin selector. Scans requesters starting at    |
// | last_owner+1 (wrapping modulo NUM_REQ) and picks the first active.   |
// | Ports:                                                               |
// |   req        in  NUM_REQ  active requests                            |
// |   last_owner in  IDX_W    index of the most recent owner             |
// |   pick       out NUM_REQ  one-hot winner (zero when none active)     |
// |   any        out 1        at least one request active                |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module usb_rr_picker
  import usb_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    cand = '0;
    // Offsets 1..NUM_REQ visit every requester once, last_owner itself last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        pick[cand] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_arbiter                                                       |
// | Round-robin arbiter multiplexing NUM_REQ byte streams onto the USB   |
// | serial to-host byte interface, with a forced release after MAX_PKT   |
// | bytes per grant.                                                     |
// | Ports:                                                               |
// |   clk_48mhz     in   1          system clock                         |
// |   reset         in   1          synchronous active-high reset        |
// |   req_data      in   8*NUM_REQ  requester bytes, [8i+7:8i] = req i   |
// |   req_valid     in   NUM_REQ    requester byte valid                 |
// |   req_last      in   NUM_REQ    last byte of packet                  |
// |   req_ready     out  NUM_REQ    byte accepted from requester         |
// |   uart_in_data  out  8          byte to USB serial core              |
// |   uart_in_valid out  1          byte valid to USB serial core        |
// |   uart_in_ready in   1          USB serial core accepts byte         |
// |   grant         out  NUM_REQ    one-hot owner, zero when idle        |
// |   busy          out  1          arbiter in BUSY                      |
// |   trunc         out  1          pulse on forced release at MAX_PKT   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module usb_tx_arbiter
  import usb_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int MAX_PKT = DEF_MAX_PKT
) (
  input  logic                      clk_48mhz,
  input  logic                      reset,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         uart_in_data,
  output logic                      uart_in_valid,
  input  logic                      uart_in_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      trunc
);

  localparam int         IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] LAST_CNT = 8'(MAX_PKT - 1);

  state_t               state, state_next;
  logic [NUM_REQ-1:0]   grant_next;
  logic [NUM_REQ-1:0]   pick;
  logic                 pick_any;
  logic [IDX_W-1:0]     last_owner, owner_next, grant_idx;
  logic [7:0]           byte_cnt, cnt_next;
  logic                 trunc_next;
  logic                 out_free;
  logic                 accept;
  logic                 sel_last;
  logic [BYTE_W-1:0]    sel_data;

  assign busy     = (state == BUSY);
  // Output stage can take a byte when empty or being drained this cycle.
  assign out_free = ~uart_in_valid | uart_in_ready;
  // Reset gating keeps ready low for the whole reset pulse, even in the
  // first reset cycle while the registers still hold BUSY.
  assign req_ready = grant & {NUM_REQ{busy & out_free & ~reset}};
  assign accept    = |(req_valid & req_ready);

  usb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .last_owner (last_owner),
    .pick       (pick),
    .any        (pick_any)
  );

  // Owner mux: grant is one-hot, so at most one iteration matches.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data  = req_data[i*BYTE_W +: BYTE_W];
        sel_last  = req_last[i];
        grant_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    owner_next = last_owner;
    cnt_next   = byte_cnt;
    trunc_next = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_next = BUSY;
          grant_next = pick;
          cnt_next   = '0;
        end
      end
      BUSY: begin
        if (accept) begin
          cnt_next = byte_cnt + 8'd1;
          // A last byte wins over the size limit: the release is normal.
          if (sel_last || byte_cnt == LAST_CNT) begin
            state_next = IDLE;
            grant_next = '0;
            owner_next = grant_idx;
            trunc_next = ~sel_last;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      byte_cnt   <= '0;
      trunc      <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_owner <= owner_next;
      byte_cnt   <= cnt_next;
      trunc      <= trunc_next;
    end
  end

  // Single-stage output register: loads on accept, clears on a drain with
  // no replacement, otherwise holds.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      uart_in_data  <= '0;
      uart_in_valid <= 1'b0;
    end else if (accept) begin
      uart_in_data  <= sel_data;
      uart_in_valid <= 1'b1;
    end else if (uart_in_ready) begin
      uart_in_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_usb_tx_arbiter                                                    |
// | Scoreboard bench for usb_tx_arbiter. Requester streams are loaded    |
// | up front; a packet-level round-robin model derives the expected      |
// | byte stream, grant order and truncation count; a monitor process     |
// | compares the DUT outputs against the queued expectations.            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_usb_tx_arbiter;

  localparam int N     = 3;
  localparam int MAXP  = 64;
  localparam int DEPTH = 256;

  logic             clk_48mhz = 1'b0;
  logic             reset = 1'b1;
  logic [8*N-1:0]   req_data = '0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_last = '0;
  logic [N-1:0]     req_ready;
  logic [7:0]       uart_in_data;
  logic             uart_in_valid;
  logic             uart_in_ready = 1'b0;
  logic [N-1:0]     grant;
  logic             busy;
  logic             trunc;

  usb_tx_arbiter #(.NUM_REQ(N), .MAX_PKT(MAXP)) dut (
    .clk_48mhz     (clk_48mhz),
    .reset         (reset),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_in_data  (uart_in_data),
    .uart_in_valid (uart_in_valid),
    .uart_in_ready (uart_in_ready),
    .grant         (grant),
    .busy          (busy),
    .trunc         (trunc)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  int total = 0;
  int bad   = 0;

  // Requester streams: {last, byte} per entry.
  logic [8:0] stream [N][DEPTH];
  int         len [N];
  int         rd  [N];
  logic [N-1:0] acc = '0;
  logic [7:0]   acc_byte = '0;

  logic rst_want  = 1'b1;
  logic gaps_en   = 1'b0;
  int   rdy_mode  = 0;
  logic rdy_force = 1'b1;

  logic [7:0] sb_q [$];
  int         gnt_q [$];
  int         exp_trunc = 0;
  int         trunc_seen = 0;
  int         cyc = 0;
  int         first_busy = -1;
  int         last_acc = -1;
  logic [N-1:0] prev_grant = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus: retire last cycle's accepts, drive, sample handshake.
  task automatic step();
    logic mid;
    @(negedge clk_48mhz);
    for (int i = 0; i < N; i++) if (acc[i]) rd[i]++;
    if (|acc) begin
      check("latency_valid", 32'(uart_in_valid), 32'd1);
      check("latency_data", 32'(uart_in_data), 32'(acc_byte));
    end
    reset = rst_want;
    case (rdy_mode)
      0:       uart_in_ready = 1'b1;
      1:       uart_in_ready = 1'($urandom_range(0, 1));
      default: uart_in_ready = rdy_force;
    endcase
    for (int i = 0; i < N; i++) begin
      if (rd[i] < len[i]) begin
        req_data[i*8 +: 8] = stream[i][rd[i]][7:0];
        req_last[i]        = stream[i][rd[i]][8];
        mid = (rd[i] > 0) && !stream[i][rd[i]-1][8];
        req_valid[i] = !(gaps_en && mid && ($urandom_range(0, 3) == 0));
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
    #1;
    acc = req_valid & req_ready;
    acc_byte = '0;
    for (int i = 0; i < N; i++) if (acc[i]) acc_byte = req_data[i*8 +: 8];
    if (reset) begin
      check("ready_in_reset", 32'(req_ready), 32'd0);
    end else begin
      cyc++;
      if (busy && first_busy < 0) first_busy = cyc;
      if (|acc) last_acc = cyc;
    end
  endtask

  task automatic clear_all();
    sb_q.delete();
    gnt_q.delete();
    for (int i = 0; i < N; i++) begin len[i] = 0; rd[i] = 0; end
    exp_trunc = 0; trunc_seen = 0; cyc = 0; first_busy = -1; last_acc = -1;
    acc = '0;
  endtask

  task automatic do_reset();
    rst_want = 1'b1;
    step();
    step();
    clear_all();
  endtask

  task automatic add_pkt(input int r, input int n, input logic last_flag);
    for (int k = 0; k < n; k++) begin
      stream[r][len[r]] = {(k == n - 1) && last_flag, 8'($urandom)};
      len[r]++;
    end
  endtask

  // Packet-level model: round robin over requesters with data left; a grant
  // carries bytes until a last marker or MAXP bytes. A requester that runs
  // dry mid-grant keeps the channel forever, so the model stops there.
  task automatic build_model();
    int pos [N];
    int owner;
    int pick;
    int n;
    logic done;
    owner = N - 1;
    for (int i = 0; i < N; i++) pos[i] = 0;
    while (1) begin
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && pos[(owner + k) % N] < len[(owner + k) % N]) pick = (owner + k) % N;
      if (pick < 0) break;
      gnt_q.push_back(pick);
      n = 0;
      done = 1'b0;
      while (!done) begin
        if (pos[pick] >= len[pick]) return;
        sb_q.push_back(stream[pick][pos[pick]][7:0]);
        n++;
        if (stream[pick][pos[pick]][8]) done = 1'b1;
        else if (n == MAXP) begin done = 1'b1; exp_trunc++; end
        pos[pick]++;
      end
      owner = pick;
    end
  endtask

  task automatic run_drain(input string name, input int budget);
    int c = 0;
    while ((sb_q.size() != 0 || uart_in_valid) && c < budget) begin
      step();
      c++;
    end
    check({name, "_left"}, 32'(sb_q.size()), 32'd0);
    step();
    step();
    check({name, "_trunc"}, 32'(trunc_seen), 32'(exp_trunc));
    check({name, "_grants_left"}, 32'(gnt_q.size()), 32'd0);
  endtask

  // Monitor: output bytes against the scoreboard head, grant onsets against
  // the expected owner order, trunc pulses counted.
  initial begin
    forever begin
      @(negedge clk_48mhz);
      #2;
      if (reset) begin
        prev_grant = '0;
      end else begin
        if (uart_in_valid) begin
          if (sb_q.size() == 0) check("unexpected_byte", 32'(uart_in_valid), 32'd0);
          else begin
            check("out_data", 32'(uart_in_data), 32'(sb_q[0]));
            if (uart_in_ready) void'(sb_q.pop_front());
          end
        end
        if (prev_grant == '0 && grant != '0) begin
          if (gnt_q.size() == 0) check("grant_unexpected", 32'(grant), 32'd0);
          else check("grant_owner", 32'(grant), 32'(1) << gnt_q.pop_front());
        end
        prev_grant = grant;
        if (trunc) trunc_seen++;
      end
    end
  end

  initial begin
    int exp_span;
    int c;
    clear_all();
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_trunc", 32'(trunc), 32'd0);
    check("rst_valid", 32'(uart_in_valid), 32'd0);
    check("rst_data", 32'(uart_in_data), 32'd0);

    // Single-byte packets from all three: order 0,1,2,0, 1 idle cycle between.
    rdy_mode = 0;
    add_pkt(0, 1, 1'b1); add_pkt(0, 1, 1'b1);
    add_pkt(1, 1, 1'b1); add_pkt(2, 1, 1'b1);
    build_model();
    exp_span = sb_q.size() + gnt_q.size() - 1;
    rst_want = 1'b0;
    run_drain("single", 200);
    check("single_span", 32'(last_acc - first_busy + 1), 32'(exp_span));

    // "hello" from requester 1 with a 3-cycle sink stall mid-packet.
    do_reset();
    stream[1][0] = 9'h068; stream[1][1] = 9'h065; stream[1][2] = 9'h06c;
    stream[1][3] = 9'h06c; stream[1][4] = 9'h16f; len[1] = 5;
    build_model();
    rdy_mode = 2;
    rst_want = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rdy_force = !(k >= 3 && k < 6);
      step();
    end
    rdy_force = 1'b1;
    run_drain("hello", 200);
    check("hello_grant_idle", 32'(grant), 32'd0);
    check("hello_busy_idle", 32'(busy), 32'd0);

    // 70 bytes without last from requester 2, requester 0 waiting with two
    // short packets: trunc at the 64th byte, channel then goes to 0.
    do_reset();
    rdy_mode = 0;
    add_pkt(2, 70, 1'b0);
    add_pkt(0, 2, 1'b1); add_pkt(0, 2, 1'b1);
    build_model();
    rst_want = 1'b0;
    run_drain("trunc70", 1000);

    // Last on exactly the 64th byte is a normal release; 65 bytes truncates.
    do_reset();
    add_pkt(0, 64, 1'b1);
    add_pkt(1, 65, 1'b1);
    build_model();
    rst_want = 1'b0;
    run_drain("edge64", 1000);

    // Reset while BUSY with a stalled output byte.
    do_reset();
    rdy_mode = 2;
    rdy_force = 1'b1;
    add_pkt(1, 10, 1'b1);
    build_model();
    rst_want = 1'b0;
    step(); step(); step();
    rdy_force = 1'b0;
    step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_valid", 32'(uart_in_valid), 32'd1);
    rst_want = 1'b1;
    step();
    step();
    check("midrst_valid", 32'(uart_in_valid), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    do_reset();
    rdy_force = 1'b1;
    add_pkt(0, 1, 1'b1); add_pkt(1, 1, 1'b1); add_pkt(2, 1, 1'b1);
    build_model();
    rst_want = 1'b0;
    run_drain("after_rst", 200);

    // Random packets, sink always ready: full throughput, 1-cycle gaps.
    do_reset();
    rdy_mode = 0;
    for (int r = 0; r < N; r++) begin
      c = $urandom_range(1, 4);
      for (int p = 0; p < c; p++) add_pkt(r, $urandom_range(1, 20), 1'b1);
    end
    build_model();
    exp_span = sb_q.size() + gnt_q.size() - 1;
    rst_want = 1'b0;
    run_drain("rand_full", 2000);
    check("rand_full_span", 32'(last_acc - first_busy + 1), 32'(exp_span));

    // Random packets up to MAXP, random sink stalls and requester gaps.
    do_reset();
    rdy_mode = 1;
    gaps_en = 1'b1;
    for (int r = 0; r < N; r++) begin
      c = $urandom_range(1, 3);
      for (int p = 0; p < c; p++) add_pkt(r, $urandom_range(1, MAXP), 1'b1);
    end
    build_model();
    rst_want = 1'b0;
    run_drain("rand_stall", 8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_tx_arbiter.md
USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3; number of byte-stream requesters sharing the USB serial to-host channel.
REQ-002 Parameter MAX_PKT, default 64; maximum bytes per grant before a forced release.
REQ-003 The port list SHALL be exactly:
- clk_48mhz  in  1  system clock; the single clock.
- reset  in  1  synchronous, active-high reset.
- req_data  in  8*NUM_REQ  byte per requester; requester i uses bits [8i+7:8i].
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_last  in  NUM_REQ  per-requester last byte of packet, qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester byte accepted when req_valid is also high.
- uart_in_data  out  8  byte to the USB serial core.
- uart_in_valid  out  1  byte valid to the USB serial core.
- uart_in_ready  in  1  USB serial core accepts the byte.
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy  out  1  high in BUSY state.
- trunc  out  1  one-cycle pulse on a forced release at MAX_PKT.

Function
REQ-004 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-005 In IDLE with any req_valid high, the block SHALL select a requester round-robin, starting from last_owner+1 modulo NUM_REQ.
REQ-006 On selection, the block SHALL load grant and move to BUSY on the next edge; no byte is accepted in the IDLE cycle.
REQ-007 In IDLE with no req_valid high, the state and last_owner SHALL hold.
REQ-008 req_ready[i] SHALL equal busy & grant[i] & (~uart_in_valid | uart_in_ready), combinationally; all other req_ready bits are 0.
REQ-009 An accepted byte (req_valid[i] & req_ready[i]) SHALL appear on uart_in_data with uart_in_valid high on the following cycle (1-cycle latency).
REQ-010 The output register SHALL be a single stage: uart_in_data and uart_in_valid hold stable while uart_in_valid & ~uart_in_ready.
REQ-011 A simultaneous accept and drain SHALL sustain 1 byte per cycle.
REQ-012 uart_in_valid SHALL clear after a drain that has no new accept.
REQ-013 An 8-bit byte counter SHALL clear on entry to BUSY and increment on each accept.
REQ-014 An accept with req_last high SHALL return the FSM to IDLE and clear grant.
REQ-015 An accept without req_last that is the MAX_PKT-th byte SHALL do the same and pulse trunc for one cycle.
REQ-016 On either release, last_owner SHALL be set to the released index.
REQ-017 When last and the MAX_PKT-th byte coincide, the release SHALL be normal with trunc = 0.
REQ-018 The pending output byte at release SHALL still drain normally; a new grant may be issued while it drains.
REQ-019 Requester valid/data changes while not granted SHALL have no effect.
REQ-020 A granted requester dropping req_valid SHALL keep its grant; the arbiter waits without a timeout.

Reset
REQ-021 On reset the block SHALL set: state IDLE, grant 0, busy 0, trunc 0, uart_in_valid 0, uart_in_data 8'h00, byte counter 0, last_owner NUM_REQ-1 (requester 0 wins first).
REQ-022 Reset asserted mid-packet or with a pending output byte SHALL discard that byte; no partial state survives.
REQ-023 req_ready SHALL be 0 throughout reset.

Structure
REQ-024 Package usb_tx_arb_pkg SHALL hold the state enum (IDLE, BUSY), the default NUM_REQ and MAX_PKT constants, and the byte width (8).
REQ-025 The round-robin selection SHALL be a separate combinational sub-module, usb_rr_picker: inputs req vector and last_owner; outputs one-hot pick and any.

Verification
REQ-026 Reset release, then req_valid=3'b111 with single-byte packets (last=1) -> grants in order 0,1,2,0; each byte on uart_in_data one cycle after accept.
REQ-027 Requester 1 sends 5 bytes 8'h68,65,6c,6c,6f (last on 8'h6f) with uart_in_ready stalled low 3 cycles mid-packet -> bytes delivered in order, data held stable during the stall, grant returns to 0 after the last accept.
REQ-028 Requester 2 streams 70 bytes without last, MAX_PKT=64 -> trunc pulses once at the 64th accept; the next grant goes to another waiting requester, or to 2 again if alone.
REQ-029 63 bytes, then a 64th with last=1 -> normal release, trunc stays 0.
REQ-030 Reset asserted while BUSY with uart_in_valid=1 -> the next cycle shows uart_in_valid 0, grant 0, and requester 0 is granted first afterwards.
REQ-031 uart_in_ready held 1 with continuous valid -> 1 byte/cycle throughput; the IDLE gap between packets is exactly 1 cycle.
